// File: rtl/calc_unit_sequencer.sv
// calc_unit_sequencer: issues in_buf/kn_buf reads for an OC x IC tile, aligns CU en/reset/we to the
// returned data and emits one out_buf write per oc. Define CALC_SEQ_PERF_EN to add perf counters.
module calc_unit_sequencer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned IC_WIDTH   = 8,
    parameter int unsigned OC_WIDTH   = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned CU_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    input  logic [IC_WIDTH-1:0]   ic_count,
    input  logic [OC_WIDTH-1:0]   oc_count,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [ADDR_WIDTH-1:0] kn_base,
    input  logic [ADDR_WIDTH-1:0] out_base,
    output logic [ADDR_WIDTH-1:0] in_buf_raddr,
    output logic [ADDR_WIDTH-1:0] kn_buf_raddr,
    output logic                  cu_en,
    output logic                  cu_reset,
    output logic                  cu_we,
    output logic                  out_we,
    output logic [ADDR_WIDTH-1:0] out_waddr,
`ifdef CALC_SEQ_PERF_EN
    output logic [31:0]           perf_busy_cycles,
    output logic [31:0]           perf_hold_cycles,
`endif
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic                valid;
        logic                first;
        logic                last;
        logic [OC_WIDTH-1:0] oc;
    } tag_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
    } wr_t;

    state_t                state_q, state_d;
    logic [IC_WIDTH-1:0]   ic_cnt_q, ic_cnt_d;
    logic [OC_WIDTH-1:0]   oc_cnt_q, oc_cnt_d;
    logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
    logic [ADDR_WIDTH-1:0] kn_base_q, kn_base_d;
    logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
    logic [IC_WIDTH-1:0]   ic_q, ic_d;
    logic [OC_WIDTH-1:0]   oc_q, oc_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [ADDR_WIDTH-1:0] in_raddr_q, in_raddr_d;
    logic [ADDR_WIDTH-1:0] kn_raddr_q, kn_raddr_d;
    tag_t                  tag_q [RD_LATENCY+1];
    tag_t                  tag_d [RD_LATENCY+1];
    wr_t                   wr_q  [CU_LATENCY];
    wr_t                   wr_d  [CU_LATENCY];

    logic                  issue;
    logic                  is_last;
    logic                  inflight;
    logic [IC_WIDTH-1:0]   cur_ic;
    logic [IC_WIDTH-1:0]   cur_icn;
    logic [OC_WIDTH-1:0]   cur_oc;
    logic [ADDR_WIDTH-1:0] cur_k;
    logic [ADDR_WIDTH-1:0] cur_in_base;
    logic [ADDR_WIDTH-1:0] cur_kn_base;

    // Anything still travelling toward out_we keeps DRAIN alive; the out_we stage itself does not,
    // so DONE lands on the cycle right after the final write.
    always_comb begin
        inflight = 1'b0;
        for (int unsigned i = 0; i <= RD_LATENCY; i++) begin
            inflight = inflight | tag_q[i].valid;
        end
        for (int unsigned i = 0; i + 1 < CU_LATENCY; i++) begin
            inflight = inflight | wr_q[i].we;
        end
    end

    always_comb begin
        state_d    = state_q;
        ic_cnt_d   = ic_cnt_q;
        oc_cnt_d   = oc_cnt_q;
        in_base_d  = in_base_q;
        kn_base_d  = kn_base_q;
        out_base_d = out_base_q;
        ic_d       = ic_q;
        oc_d       = oc_q;
        k_d        = k_q;
        in_raddr_d = in_raddr_q;
        kn_raddr_d = kn_raddr_q;
        issue      = 1'b0;

        // The first word is issued on the same edge that accepts start, straight from the inputs.
        if (state_q == S_IDLE) begin
            cur_ic      = '0;
            cur_oc      = '0;
            cur_k       = '0;
            cur_icn     = ic_count;
            cur_in_base = in_base;
            cur_kn_base = kn_base;
        end else begin
            cur_ic      = ic_q;
            cur_oc      = oc_q;
            cur_k       = k_q;
            cur_icn     = ic_cnt_q;
            cur_in_base = in_base_q;
            cur_kn_base = kn_base_q;
        end
        is_last = (cur_ic == cur_icn - IC_WIDTH'(1));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ic_cnt_d   = ic_count;
                    oc_cnt_d   = oc_count;
                    in_base_d  = in_base;
                    kn_base_d  = kn_base;
                    out_base_d = out_base;
                    ic_d       = '0;
                    oc_d       = '0;
                    k_d        = '0;
                    // An empty tile passes through DRAIN (pipeline already empty) so done
                    // arrives two cycles after start.
                    if ((ic_count == '0) || (oc_count == '0)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                        issue   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (oc_q == oc_cnt_q) begin
                    state_d = S_DRAIN;
                end else if (!hold) begin
                    issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!inflight) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            in_raddr_d = cur_in_base + ADDR_WIDTH'(cur_ic);
            kn_raddr_d = cur_kn_base + cur_k;
            k_d        = cur_k + ADDR_WIDTH'(1);
            if (is_last) begin
                ic_d = '0;
                oc_d = cur_oc + OC_WIDTH'(1);
            end else begin
                ic_d = cur_ic + IC_WIDTH'(1);
                oc_d = cur_oc;
            end
        end

        tag_d[0].valid = issue;
        tag_d[0].first = (cur_ic == '0);
        tag_d[0].last  = is_last;
        tag_d[0].oc    = cur_oc;
        for (int unsigned i = 1; i <= RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        wr_d[0].we   = tag_q[RD_LATENCY].valid & tag_q[RD_LATENCY].last;
        wr_d[0].addr = out_base_q + ADDR_WIDTH'(tag_q[RD_LATENCY].oc);
        for (int unsigned i = 1; i < CU_LATENCY; i++) begin
            wr_d[i] = wr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ic_cnt_q   <= '0;
            oc_cnt_q   <= '0;
            in_base_q  <= '0;
            kn_base_q  <= '0;
            out_base_q <= '0;
            ic_q       <= '0;
            oc_q       <= '0;
            k_q        <= '0;
            in_raddr_q <= '0;
            kn_raddr_q <= '0;
            for (int unsigned i = 0; i <= RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            for (int unsigned i = 0; i < CU_LATENCY; i++) begin
                wr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ic_cnt_q   <= ic_cnt_d;
            oc_cnt_q   <= oc_cnt_d;
            in_base_q  <= in_base_d;
            kn_base_q  <= kn_base_d;
            out_base_q <= out_base_d;
            ic_q       <= ic_d;
            oc_q       <= oc_d;
            k_q        <= k_d;
            in_raddr_q <= in_raddr_d;
            kn_raddr_q <= kn_raddr_d;
            for (int unsigned i = 0; i <= RD_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
            for (int unsigned i = 0; i < CU_LATENCY; i++) begin
                wr_q[i] <= wr_d[i];
            end
        end
    end

`ifdef CALC_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_hold_q, perf_hold_d;

    always_comb begin
        perf_busy_d = perf_busy_q;
        perf_hold_d = perf_hold_q;
        if ((state_q == S_IDLE) && start) begin
            perf_busy_d = '0;
            perf_hold_d = '0;
        end else begin
            if ((state_q != S_IDLE) && (perf_busy_q != '1)) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
            if ((state_q == S_ISSUE) && hold && (perf_hold_q != '1)) begin
                perf_hold_d = perf_hold_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q <= '0;
            perf_hold_q <= '0;
        end else begin
            perf_busy_q <= perf_busy_d;
            perf_hold_q <= perf_hold_d;
        end
    end

    assign perf_busy_cycles = perf_busy_q;
    assign perf_hold_cycles = perf_hold_q;
`endif

    assign in_buf_raddr = in_raddr_q;
    assign kn_buf_raddr = kn_raddr_q;
    assign cu_en        = tag_q[RD_LATENCY].valid;
    assign cu_reset     = tag_q[RD_LATENCY].valid & tag_q[RD_LATENCY].first;
    assign cu_we        = tag_q[RD_LATENCY].valid & tag_q[RD_LATENCY].last;
    assign out_we       = wr_q[CU_LATENCY-1].we;
    assign out_waddr    = wr_q[CU_LATENCY-1].addr;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_calc_unit_sequencer.sv
// Bench for calc_unit_sequencer: random tiles checked cycle by cycle against a word-index event model.
module tb_calc_unit_sequencer;

    localparam int AW    = 12;
    localparam int IW    = 8;
    localparam int OW    = 8;
    localparam int RD    = 1;
    localparam int CU    = 2;
    localparam int NEVER = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hold;
    logic [IW-1:0] ic_count;
    logic [OW-1:0] oc_count;
    logic [AW-1:0] in_base;
    logic [AW-1:0] kn_base;
    logic [AW-1:0] out_base;
    logic [AW-1:0] in_buf_raddr;
    logic [AW-1:0] kn_buf_raddr;
    logic          cu_en;
    logic          cu_reset;
    logic          cu_we;
    logic          out_we;
    logic [AW-1:0] out_waddr;
    logic          busy;
    logic          done;
`ifdef CALC_SEQ_PERF_EN
    logic [31:0]   perf_busy_cycles;
    logic [31:0]   perf_hold_cycles;
`endif

    always #5 clk = ~clk;

    calc_unit_sequencer #(
        .ADDR_WIDTH (AW),
        .IC_WIDTH   (IW),
        .OC_WIDTH   (OW),
        .RD_LATENCY (RD),
        .CU_LATENCY (CU)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hold         (hold),
        .ic_count     (ic_count),
        .oc_count     (oc_count),
        .in_base      (in_base),
        .kn_base      (kn_base),
        .out_base     (out_base),
        .in_buf_raddr (in_buf_raddr),
        .kn_buf_raddr (kn_buf_raddr),
        .cu_en        (cu_en),
        .cu_reset     (cu_reset),
        .cu_we        (cu_we),
        .out_we       (out_we),
        .out_waddr    (out_waddr),
`ifdef CALC_SEQ_PERF_EN
        .perf_busy_cycles (perf_busy_cycles),
        .perf_hold_cycles (perf_hold_cycles),
`endif
        .busy         (busy),
        .done         (done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: word j of a tile is ic=j%icn, oc=j/icn; everything else is event times.
    int       cyc        = 0;
    bit       active     = 1'b0;
    int       s_cyc      = 0;
    int       done_cyc   = NEVER;
    int       t_last     = NEVER;
    int       m_icn      = 0;
    int       m_ocn      = 0;
    int       n_total    = 0;
    int       j_next     = 0;
    int       m_in       = 0;
    int       m_kn       = 0;
    int       m_out      = 0;
    int       exp_in     = 0;
    int       exp_kn     = 0;
    int       perf_busy  = 0;
    int       perf_hold  = 0;
    int       obs_done   = -1;
    int       last_start = 0;
    bit [2:0] cu_ev [int];
    int       out_ev [int];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_busy(input int c);
        return active && (c > s_cyc) && (c <= done_cyc);
    endfunction

    task automatic model_issue();
        int j, ic, oc;
        j      = j_next;
        ic     = j % m_icn;
        oc     = j / m_icn;
        exp_in = (m_in + ic) % 4096;
        exp_kn = (m_kn + j) % 4096;
        cu_ev[cyc + 1 + RD] = {1'b1, 1'(ic == 0), 1'(ic == m_icn - 1)};
        if (ic == m_icn - 1) out_ev[cyc + 1 + RD + CU] = (m_out + oc) % 4096;
        j_next++;
        if (j_next == n_total) begin
            t_last   = cyc + 1;
            done_cyc = cyc + 2 + RD + CU;
        end
    endtask

    task automatic model_edge(input bit s, input bit h, input bit r);
        if (r) begin
            active    = 1'b0;
            done_cyc  = NEVER;
            exp_in    = 0;
            exp_kn    = 0;
            perf_busy = 0;
            perf_hold = 0;
            cu_ev.delete();
            out_ev.delete();
        end else begin
            if (exp_busy(cyc)) perf_busy++;
            if (active && (cyc > s_cyc) && (cyc <= t_last) && h) perf_hold++;
            if (s && !exp_busy(cyc)) begin
                active    = 1'b1;
                s_cyc     = cyc;
                m_icn     = int'(ic_count);
                m_ocn     = int'(oc_count);
                m_in      = int'(in_base);
                m_kn      = int'(kn_base);
                m_out     = int'(out_base);
                n_total   = m_icn * m_ocn;
                j_next    = 0;
                perf_busy = 0;
                perf_hold = 0;
                if (n_total == 0) begin
                    done_cyc = cyc + 2;
                    t_last   = cyc;
                end else begin
                    done_cyc = NEVER;
                    t_last   = NEVER;
                    model_issue();
                end
            end else if (active && (cyc > s_cyc) && (j_next < n_total) && !h) begin
                model_issue();
            end
        end
    endtask

    task automatic check_cycle();
        bit [2:0] ecu;
        bit       ewe;
        ecu = cu_ev.exists(cyc) ? cu_ev[cyc] : 3'b000;
        ewe = out_ev.exists(cyc) != 0;
        check_eq("in_raddr", 32'(in_buf_raddr), 32'(exp_in));
        check_eq("kn_raddr", 32'(kn_buf_raddr), 32'(exp_kn));
        check_eq("cu_en_reset_we", 32'({cu_en, cu_reset, cu_we}), 32'(ecu));
        check_eq("out_we", 32'(out_we), 32'(ewe));
        if (ewe) check_eq("out_waddr", 32'(out_waddr), 32'(out_ev[cyc]));
        check_eq("busy", 32'(busy), 32'(exp_busy(cyc)));
        check_eq("done", 32'(done), 32'(active && (cyc == done_cyc)));
        if (done === 1'b1) obs_done = cyc;
    endtask

    task automatic cycle(input bit s, input bit h, input bit r);
        start = s;
        hold  = h;
        rst   = r;
        model_edge(s, h, r);
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic run_tile(input int icn, input int ocn, input int inb, input int knb, input int outb,
                            input int hold_pct, input int hold_a, input int hold_b,
                            input int rst_off, input bit spurious);
        int rel;
        bit h, r, sp;
        ic_count   = IW'(icn);
        oc_count   = OW'(ocn);
        in_base    = AW'(inb);
        kn_base    = AW'(knb);
        out_base   = AW'(outb);
        obs_done   = -1;
        last_start = cyc;
        cycle(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            if (!active || (cyc > done_cyc)) break;
            rel = cyc - last_start;
            h   = ((rel >= hold_a) && (rel <= hold_b)) || (int'($urandom_range(99)) < hold_pct);
            r   = (rel == rst_off);
            sp  = spurious && exp_busy(cyc) && ($urandom_range(3) == 0);
            if (sp) begin
                ic_count = IW'($urandom);
                oc_count = OW'($urandom);
                in_base  = AW'($urandom);
            end
            cycle(sp, h, r);
        end
        check_eq("tile_finished", 32'(!active || (cyc > done_cyc)), 32'd1);
`ifdef CALC_SEQ_PERF_EN
        if (active) begin
            check_eq("perf_busy", perf_busy_cycles, 32'(perf_busy));
            check_eq("perf_hold", perf_hold_cycles, 32'(perf_hold));
        end
`endif
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        hold     = 1'b0;
        ic_count = '0;
        oc_count = '0;
        in_base  = '0;
        kn_base  = '0;
        out_base = '0;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // Directed tiles, with end-to-end latency measured from the DUT's own done pulse.
        run_tile(2, 1, 'h10, 'h20, 'h30, 0, -1, -1, -1, 1'b0);
        check_eq("t1_done_latency", 32'(obs_done - last_start), 32'(1 + 2 + RD + CU));
        run_tile(1, 3, 'h10, 'h20, 'h30, 0, -1, -1, -1, 1'b0);
        check_eq("t2_done_latency", 32'(obs_done - last_start), 32'(1 + 3 + RD + CU));
        run_tile(4, 2, 'h10, 'h20, 'h30, 0, 2, 3, -1, 1'b0);
        check_eq("t3_done_latency", 32'(obs_done - last_start), 32'(1 + 8 + RD + CU + 2));
        run_tile(0, 5, 'h10, 'h20, 'h30, 0, -1, -1, -1, 1'b1);
        check_eq("t4_ic0_done_latency", 32'(obs_done - last_start), 32'd2);
        run_tile(3, 0, 'h10, 'h20, 'h30, 0, -1, -1, -1, 1'b1);
        check_eq("t4_oc0_done_latency", 32'(obs_done - last_start), 32'd2);
        run_tile(3, 4, 'h40, 'h50, 'h60, 0, -1, -1, -1, 1'b1);
        run_tile(4, 4, 'h10, 'h20, 'h30, 0, -1, -1, 5, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        run_tile(2, 2, 'h10, 'h20, 'h30, 0, -1, -1, -1, 1'b0);
        run_tile(3, 2, 'hFFE, 'hFFD, 'hFFF, 20, -1, -1, -1, 1'b1);

        for (int t = 0; t < 30; t++) begin
            run_tile(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                     int'($urandom_range(0, 4095)), int'($urandom_range(0, 40)), -1, -1,
                     ($urandom_range(7) == 0) ? int'($urandom_range(1, 12)) : -1, 1'b1);
            if (!active) cycle(1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
